// File: rtl/conv_param_gen.sv
// Convolution parameter pre-compute: latches one descriptor, validates it, derives loop bounds and tails.
// Latency: done/enable rise TENSOR_W+8 edges after start is sampled; 3 edges for a rejected descriptor.
// Backpressure: none; start is sampled only in IDLE and is dropped (not queued) while busy.
//
// Optional feature macro: CONV_PAD_EN adds the padding port (P); when undefined, P = 0.
// Ports: clk, rstn (async active-low); start + descriptor (tensor_size T, kernel_size K, channels C,
//        stride S, kernel_nums N [, padding P]); status busy/done/cfg_err/enable; results out_dim,
//        t_tms, kkc, row_blocks/row_tail, kn_blocks/kn_tail, it_blocks/it_tail.
module conv_param_gen #(
   parameter  int TENSOR_W   = 8,
   parameter  int KERNEL_W   = 4,
   parameter  int CHANNELS_W = 8,
   parameter  int STRIDE_W   = 3,
   parameter  int KNUMS_W    = 8,
   parameter  int ADDR_W     = 16,
   parameter  int LANES      = 8,
   localparam int LW         = $clog2(LANES)
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             start,
   input  logic [TENSOR_W-1:0]              tensor_size,
   input  logic [KERNEL_W-1:0]              kernel_size,
   input  logic [CHANNELS_W-1:0]            channels,
   input  logic [STRIDE_W-1:0]              stride,
   input  logic [KNUMS_W-1:0]               kernel_nums,
`ifdef CONV_PAD_EN
   input  logic [KERNEL_W-2:0]              padding,
`endif
   output logic                             busy,
   output logic                             done,
   output logic                             cfg_err,
   output logic                             enable,
   output logic [TENSOR_W:0]                out_dim,
   output logic [TENSOR_W+STRIDE_W-1:0]     t_tms,
   output logic [2*KERNEL_W+CHANNELS_W-1:0] kkc,
   output logic [2*KERNEL_W+CHANNELS_W-1:0] row_blocks,
   output logic [LW-1:0]                    row_tail,
   output logic [KNUMS_W-1:0]               kn_blocks,
   output logic [LW-1:0]                    kn_tail,
   output logic [ADDR_W-1:0]                it_blocks,
   output logic [LW-1:0]                    it_tail
);

   localparam int DW     = TENSOR_W + 1;          // dividend / quotient / O width
   localparam int SUM_W  = TENSOR_W + 2;          // T+2P with headroom for the K > T+2P compare
   localparam int KKC_W  = 2*KERNEL_W + CHANNELS_W;
   localparam int OO_W   = 2*DW;
   localparam int TS_W   = TENSOR_W + STRIDE_W;
   localparam int CNT_W  = $clog2(DW);
   localparam int M1     = (2*KERNEL_W > CHANNELS_W) ? 2*KERNEL_W : CHANNELS_W;
   localparam int M2     = (M1 > DW) ? M1 : DW;
   localparam int MOP_W  = (M2 > STRIDE_W) ? M2 : STRIDE_W;  // shared multiplier operand width
   localparam int PROD_W = 2*MOP_W;

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_CHECK, S_DIV, S_MUL, S_FIN, S_ERR
   } state_t;

   // ---------------------------------------------------------------- state
   state_t                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    cfg_err_q, cfg_err_d;
   logic                    enable_q, enable_d;

   // latched descriptor
   logic [TENSOR_W-1:0]     t_q, t_d;
   logic [KERNEL_W-1:0]     k_q, k_d;
   logic [CHANNELS_W-1:0]   c_q, c_d;
   logic [STRIDE_W-1:0]     s_q, s_d;
   logic [KNUMS_W-1:0]      n_q, n_d;
`ifdef CONV_PAD_EN
   logic [KERNEL_W-2:0]     p_q, p_d;
`endif

   // datapath
   logic [DW-1:0]           div_q, div_d;       // dividend, shifted into quotient, finally O
   logic [STRIDE_W-1:0]     rem_q, rem_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;       // DIV bit counter, reused as MUL step
   logic                    bad_q, bad_d;
   logic [2*KERNEL_W-1:0]   kk_q, kk_d;
   logic [KKC_W-1:0]        kkc_p_q, kkc_p_d;
   logic [OO_W-1:0]         oo_q, oo_d;
   logic [TS_W-1:0]         ts_q, ts_d;

   // registered results
   logic [TENSOR_W:0]       out_dim_q, out_dim_d;
   logic [TS_W-1:0]         t_tms_q, t_tms_d;
   logic [KKC_W-1:0]        kkc_out_q, kkc_out_d;
   logic [KKC_W-1:0]        row_blocks_q, row_blocks_d;
   logic [LW-1:0]           row_tail_q, row_tail_d;
   logic [KNUMS_W-1:0]      kn_blocks_q, kn_blocks_d;
   logic [LW-1:0]           kn_tail_q, kn_tail_d;
   logic [ADDR_W-1:0]       it_blocks_q, it_blocks_d;
   logic [LW-1:0]           it_tail_q, it_tail_d;

   // ---------------------------------------------------------------- descriptor check
   logic [SUM_W-1:0]        pad2;
   logic [SUM_W-1:0]        span;
   logic [DW-1:0]           dividend;
   logic                    bad_desc;

`ifdef CONV_PAD_EN
   assign pad2 = SUM_W'({p_q, 1'b0});
`else
   assign pad2 = '0;
`endif
   assign span     = SUM_W'(t_q) + pad2;
   // Only meaningful when K <= T+2P; otherwise the descriptor is rejected before DIV.
   assign dividend = DW'(span - SUM_W'(k_q));
   assign bad_desc = (k_q == '0) || (s_q == '0) || (c_q == '0) || (n_q == '0) ||
                     (SUM_W'(k_q) > span);

   // ---------------------------------------------------------------- restoring divider step
   // The dividend MSB shifts into the partial remainder while the quotient bit shifts in at the LSB,
   // so after DW steps div_q holds floor(D/S). The remainder never exceeds S-1.
   logic [STRIDE_W:0]       rem_sh;
   logic                    rem_ge;
   logic [STRIDE_W-1:0]     rem_nx;
   logic [DW-1:0]           quo_nx;

   assign rem_sh = {rem_q, div_q[DW-1]};
   assign rem_ge = (rem_sh >= {1'b0, s_q});
   assign rem_nx = rem_ge ? STRIDE_W'(rem_sh - {1'b0, s_q}) : rem_sh[STRIDE_W-1:0];
   assign quo_nx = {div_q[DW-2:0], rem_ge};

   // ---------------------------------------------------------------- shared multiplier
   logic [MOP_W-1:0]        mul_a, mul_b;
   logic [PROD_W-1:0]       mul_p;

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      if (state_q == S_MUL) begin
         case (cnt_q)
            CNT_W'(0): begin mul_a = MOP_W'(k_q);   mul_b = MOP_W'(k_q);   end
            CNT_W'(1): begin mul_a = MOP_W'(kk_q);  mul_b = MOP_W'(c_q);   end
            CNT_W'(2): begin mul_a = MOP_W'(div_q); mul_b = MOP_W'(div_q); end
            default:   begin mul_a = MOP_W'(t_q);   mul_b = MOP_W'(s_q);   end
         endcase
      end
   end

   assign mul_p = PROD_W'(mul_a) * PROD_W'(mul_b);

   // ---------------------------------------------------------------- block / tail derivation
   // ceil(x/L)-1 == (x-1)>>LW and ceil(x/L) == ((x-1)>>LW)+1, both valid because x >= 1 here.
   logic [KKC_W-1:0]        kkc_m1;
   logic [KNUMS_W-1:0]      n_m1;
   logic [OO_W-1:0]         oo_m1;

   assign kkc_m1 = kkc_p_q - KKC_W'(1);
   assign n_m1   = n_q - KNUMS_W'(1);
   assign oo_m1  = oo_q - OO_W'(1);

   // ---------------------------------------------------------------- next-state logic
   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      cfg_err_d    = cfg_err_q;
      enable_d     = enable_q;
      t_d          = t_q;
      k_d          = k_q;
      c_d          = c_q;
      s_d          = s_q;
      n_d          = n_q;
`ifdef CONV_PAD_EN
      p_d          = p_q;
`endif
      div_d        = div_q;
      rem_d        = rem_q;
      cnt_d        = cnt_q;
      bad_d        = bad_q;
      kk_d         = kk_q;
      kkc_p_d      = kkc_p_q;
      oo_d         = oo_q;
      ts_d         = ts_q;
      out_dim_d    = out_dim_q;
      t_tms_d      = t_tms_q;
      kkc_out_d    = kkc_out_q;
      row_blocks_d = row_blocks_q;
      row_tail_d   = row_tail_q;
      kn_blocks_d  = kn_blocks_q;
      kn_tail_d    = kn_tail_q;
      it_blocks_d  = it_blocks_q;
      it_tail_d    = it_tail_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               t_d       = tensor_size;
               k_d       = kernel_size;
               c_d       = channels;
               s_d       = stride;
               n_d       = kernel_nums;
`ifdef CONV_PAD_EN
               p_d       = padding;
`endif
               enable_d  = 1'b0;
               cfg_err_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = S_LATCH;
            end
         end

         S_LATCH: begin
            div_d   = dividend;
            bad_d   = bad_desc;
            state_d = S_CHECK;
         end

         S_CHECK: begin
            rem_d   = '0;
            cnt_d   = '0;
            state_d = bad_q ? S_ERR : S_DIV;
         end

         S_DIV: begin
            rem_d = rem_nx;
            if (cnt_q == CNT_W'(DW-1)) begin
               div_d   = quo_nx + DW'(1);   // O = quotient + 1
               cnt_d   = '0;
               state_d = S_MUL;
            end else begin
               div_d   = quo_nx;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end

         S_MUL: begin
            cnt_d = cnt_q + CNT_W'(1);
            case (cnt_q)
               CNT_W'(0): kk_d    = mul_p[2*KERNEL_W-1:0];
               CNT_W'(1): kkc_p_d = mul_p[KKC_W-1:0];
               CNT_W'(2): oo_d    = mul_p[OO_W-1:0];
               default: begin
                  ts_d    = mul_p[TS_W-1:0];
                  state_d = S_FIN;
               end
            endcase
         end

         S_FIN: begin
            out_dim_d    = div_q;
            t_tms_d      = ts_q;
            kkc_out_d    = kkc_p_q;
            row_blocks_d = kkc_m1 >> LW;
            row_tail_d   = kkc_p_q[LW-1:0] - LW'(1);
            kn_blocks_d  = (n_m1 >> LW) + KNUMS_W'(1);
            kn_tail_d    = n_q[LW-1:0] - LW'(1);
            it_blocks_d  = ADDR_W'((oo_m1 >> LW) + OO_W'(1));
            it_tail_d    = oo_q[LW-1:0];
            done_d       = 1'b1;
            enable_d     = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
         end

         S_ERR: begin
            out_dim_d    = '0;
            t_tms_d      = '0;
            kkc_out_d    = '0;
            row_blocks_d = '0;
            row_tail_d   = '0;
            kn_blocks_d  = '0;
            kn_tail_d    = '0;
            it_blocks_d  = '0;
            it_tail_d    = '0;
            done_d       = 1'b1;
            cfg_err_d    = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
         enable_q     <= 1'b0;
         t_q          <= '0;
         k_q          <= '0;
         c_q          <= '0;
         s_q          <= '0;
         n_q          <= '0;
`ifdef CONV_PAD_EN
         p_q          <= '0;
`endif
         div_q        <= '0;
         rem_q        <= '0;
         cnt_q        <= '0;
         bad_q        <= 1'b0;
         kk_q         <= '0;
         kkc_p_q      <= '0;
         oo_q         <= '0;
         ts_q         <= '0;
         out_dim_q    <= '0;
         t_tms_q      <= '0;
         kkc_out_q    <= '0;
         row_blocks_q <= '0;
         row_tail_q   <= '0;
         kn_blocks_q  <= '0;
         kn_tail_q    <= '0;
         it_blocks_q  <= '0;
         it_tail_q    <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cfg_err_q    <= cfg_err_d;
         enable_q     <= enable_d;
         t_q          <= t_d;
         k_q          <= k_d;
         c_q          <= c_d;
         s_q          <= s_d;
         n_q          <= n_d;
`ifdef CONV_PAD_EN
         p_q          <= p_d;
`endif
         div_q        <= div_d;
         rem_q        <= rem_d;
         cnt_q        <= cnt_d;
         bad_q        <= bad_d;
         kk_q         <= kk_d;
         kkc_p_q      <= kkc_p_d;
         oo_q         <= oo_d;
         ts_q         <= ts_d;
         out_dim_q    <= out_dim_d;
         t_tms_q      <= t_tms_d;
         kkc_out_q    <= kkc_out_d;
         row_blocks_q <= row_blocks_d;
         row_tail_q   <= row_tail_d;
         kn_blocks_q  <= kn_blocks_d;
         kn_tail_q    <= kn_tail_d;
         it_blocks_q  <= it_blocks_d;
         it_tail_q    <= it_tail_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = cfg_err_q;
   assign enable     = enable_q;
   assign out_dim    = out_dim_q;
   assign t_tms      = t_tms_q;
   assign kkc        = kkc_out_q;
   assign row_blocks = row_blocks_q;
   assign row_tail   = row_tail_q;
   assign kn_blocks  = kn_blocks_q;
   assign kn_tail    = kn_tail_q;
   assign it_blocks  = it_blocks_q;
   assign it_tail    = it_tail_q;

endmodule

// File: tb/tb_conv_param_gen.sv
// Directed bench for conv_param_gen with hand-computed expected results.
`timescale 1ns/1ps
module tb_conv_param_gen;

   localparam int TW = 8, KW = 4, CW = 8, SW = 3, NW = 8, AW = 16, LANES = 8, LW = 3;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic                start = 1'b0;
   logic [TW-1:0]       tensor_size = '0;
   logic [KW-1:0]       kernel_size = '0;
   logic [CW-1:0]       channels = '0;
   logic [SW-1:0]       stride = '0;
   logic [NW-1:0]       kernel_nums = '0;
`ifdef CONV_PAD_EN
   logic [KW-2:0]       pad_in = '0;
`endif
   logic                busy, done, cfg_err, enable;
   logic [TW:0]         out_dim;
   logic [TW+SW-1:0]    t_tms;
   logic [2*KW+CW-1:0]  kkc, row_blocks;
   logic [LW-1:0]       row_tail, kn_tail, it_tail;
   logic [NW-1:0]       kn_blocks;
   logic [AW-1:0]       it_blocks;

   conv_param_gen #(
      .TENSOR_W(TW), .KERNEL_W(KW), .CHANNELS_W(CW), .STRIDE_W(SW),
      .KNUMS_W(NW), .ADDR_W(AW), .LANES(LANES)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .tensor_size(tensor_size), .kernel_size(kernel_size), .channels(channels),
      .stride(stride), .kernel_nums(kernel_nums),
`ifdef CONV_PAD_EN
      .padding(pad_in),
`endif
      .busy(busy), .done(done), .cfg_err(cfg_err), .enable(enable),
      .out_dim(out_dim), .t_tms(t_tms), .kkc(kkc),
      .row_blocks(row_blocks), .row_tail(row_tail),
      .kn_blocks(kn_blocks), .kn_tail(kn_tail),
      .it_blocks(it_blocks), .it_tail(it_tail)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [TW:0]        out_dim;
      logic [TW+SW-1:0]   t_tms;
      logic [2*KW+CW-1:0] kkc;
      logic [2*KW+CW-1:0] row_blocks;
      logic [LW-1:0]      row_tail;
      logic [NW-1:0]      kn_blocks;
      logic [LW-1:0]      kn_tail;
      logic [AW-1:0]      it_blocks;
      logic [LW-1:0]      it_tail;
   } res_t;

   int   total = 0;
   int   bad = 0;
   res_t zero_res = '0;
   res_t base_res;

   function automatic res_t get_res();
      res_t r;
      r.out_dim = out_dim;     r.t_tms = t_tms;         r.kkc = kkc;
      r.row_blocks = row_blocks; r.row_tail = row_tail;
      r.kn_blocks = kn_blocks; r.kn_tail = kn_tail;
      r.it_blocks = it_blocks; r.it_tail = it_tail;
      return r;
   endfunction

   function automatic res_t mk(input int o, input int ts, input int kk, input int rb, input int rt,
                               input int kb, input int kt, input int ib, input int it);
      res_t r;
      r.out_dim = o[TW:0];      r.t_tms = ts[TW+SW-1:0];  r.kkc = kk[2*KW+CW-1:0];
      r.row_blocks = rb[2*KW+CW-1:0]; r.row_tail = rt[LW-1:0];
      r.kn_blocks = kb[NW-1:0]; r.kn_tail = kt[LW-1:0];
      r.it_blocks = ib[AW-1:0]; r.it_tail = it[LW-1:0];
      return r;
   endfunction

   function automatic string fmt(input res_t r);
      return $sformatf("O=%0d tms=%0d kkc=%0d rb=%0d rt=%0d kb=%0d kt=%0d ib=%0d it=%0d",
                       r.out_dim, r.t_tms, r.kkc, r.row_blocks, r.row_tail,
                       r.kn_blocks, r.kn_tail, r.it_blocks, r.it_tail);
   endfunction

   // Called between edges; returns 1ns after edge 0 (the edge that samples start).
   task automatic pulse_start(input int t, input int k, input int c, input int s, input int n);
      tensor_size = t[TW-1:0];
      kernel_size = k[KW-1:0];
      channels    = c[CW-1:0];
      stride      = s[SW-1:0];
      kernel_nums = n[NW-1:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Returns the edge number (relative to edge 0) after which done is first seen high, -1 on timeout.
   task automatic wait_done(output int edge_n);
      edge_n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            edge_n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({busy, done, cfg_err, enable} !== 4'b0000) begin
         bad++; $display("FAIL reset_status: got %b want 0000", {busy, done, cfg_err, enable});
      end
      total++;
      if (get_res() !== zero_res) begin
         bad++; $display("FAIL reset_data: got %s want all zero", fmt(get_res()));
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({busy, done} !== 2'b00) begin
         bad++; $display("FAIL idle_after_reset: busy/done got %b want 00", {busy, done});
      end
   endtask

   task automatic test_baseline();
      int e;
      pulse_start(8, 3, 4, 1, 10);
      total++;
      if ({busy, enable, done} !== 3'b100) begin
         bad++; $display("FAIL base_edge0: busy/enable/done got %b want 100", {busy, enable, done});
      end
      wait_done(e);
      total++;
      if (e != 16) begin bad++; $display("FAIL base_latency: done edge %0d want 16", e); end
      total++;
      if (get_res() !== base_res) begin
         bad++; $display("FAIL base_data: got %s want %s", fmt(get_res()), fmt(base_res));
      end
      total++;
      if ({enable, busy, cfg_err} !== 3'b100) begin
         bad++; $display("FAIL base_status: enable/busy/cfg_err got %b want 100", {enable, busy, cfg_err});
      end
      @(posedge clk); #1;
      total++;
      if ({done, enable} !== 2'b01) begin
         bad++; $display("FAIL base_done_pulse: done/enable got %b want 01", {done, enable});
      end
   endtask

   task automatic test_exact();
      int e;
      res_t exp = mk(3, 24, 8, 0, 7, 2, 7, 2, 1);
      pulse_start(8, 2, 2, 3, 16);
      wait_done(e);
      total++;
      if (e != 16) begin bad++; $display("FAIL exact_latency: done edge %0d want 16", e); end
      total++;
      if (get_res() !== exp) begin
         bad++; $display("FAIL exact_data: got %s want %s", fmt(get_res()), fmt(exp));
      end
   endtask

   // Starts at the edge right after the previous done edge.
   task automatic test_back_to_back();
      int e;
      res_t exp = mk(3, 16, 18, 2, 1, 1, 7, 2, 1);
      pulse_start(8, 3, 2, 2, 8);
      total++;
      if ({busy, enable} !== 2'b10) begin
         bad++; $display("FAIL b2b_accept: busy/enable got %b want 10", {busy, enable});
      end
      wait_done(e);
      total++;
      if (e != 16) begin bad++; $display("FAIL b2b_latency: done edge %0d want 16", e); end
      total++;
      if (get_res() !== exp) begin
         bad++; $display("FAIL inexact_data: got %s want %s", fmt(get_res()), fmt(exp));
      end
   endtask

   task automatic test_boundary();
      int e;
      res_t exp;
      // K == T: zero dividend, O = 1
      exp = mk(1, 56, 64, 7, 7, 1, 0, 1, 1);
      pulse_start(8, 8, 1, 7, 1);
      wait_done(e);
      total++;
      if (e != 16 || get_res() !== exp) begin
         bad++; $display("FAIL k_eq_t: edge %0d got %s want edge 16 %s", e, fmt(get_res()), fmt(exp));
      end
      // widest values: O = 255, O*O = 65025
      exp = mk(255, 255, 255, 31, 6, 32, 6, 8129, 1);
      pulse_start(255, 1, 255, 1, 255);
      wait_done(e);
      total++;
      if (e != 16 || get_res() !== exp) begin
         bad++; $display("FAIL max_vals: edge %0d got %s want edge 16 %s", e, fmt(get_res()), fmt(exp));
      end
   endtask

   task automatic test_padding();
      int e;
      res_t exp;
`ifdef CONV_PAD_EN
      pad_in = 3'd1;
      exp = mk(5, 5, 9, 1, 0, 1, 0, 4, 1);
`else
      exp = mk(3, 5, 9, 1, 0, 1, 0, 2, 1);
`endif
      pulse_start(5, 3, 1, 1, 1);
      wait_done(e);
`ifdef CONV_PAD_EN
      pad_in = '0;
`endif
      total++;
      if (e != 16) begin bad++; $display("FAIL pad_latency: done edge %0d want 16", e); end
      total++;
      if (get_res() !== exp) begin
         bad++; $display("FAIL pad_data: got %s want %s", fmt(get_res()), fmt(exp));
      end
   endtask

   task automatic test_error();
      int e;
      int vt[5] = '{8, 8, 8, 8, 8};
      int vk[5] = '{9, 3, 3, 0, 3};
      int vc[5] = '{1, 1, 0, 1, 1};
      int vs[5] = '{1, 0, 1, 1, 1};
      int vn[5] = '{1, 1, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
         pulse_start(vt[i], vk[i], vc[i], vs[i], vn[i]);
         wait_done(e);
         total++;
         if (e != 3) begin bad++; $display("FAIL err%0d_latency: done edge %0d want 3", i, e); end
         total++;
         if ({cfg_err, enable, busy} !== 3'b100) begin
            bad++; $display("FAIL err%0d_status: cfg_err/enable/busy got %b want 100", i, {cfg_err, enable, busy});
         end
         total++;
         if (get_res() !== zero_res) begin
            bad++; $display("FAIL err%0d_data: got %s want all zero", i, fmt(get_res()));
         end
      end
      @(posedge clk); #1;
      total++;
      if ({done, cfg_err} !== 2'b01) begin
         bad++; $display("FAIL err_hold: done/cfg_err got %b want 01", {done, cfg_err});
      end
      pulse_start(8, 3, 4, 1, 10);
      total++;
      if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_clear: cfg_err got %b want 0", cfg_err); end
      wait_done(e);
      total++;
      if (e != 16 || get_res() !== base_res || cfg_err !== 1'b0) begin
         bad++; $display("FAIL err_recover: edge %0d cfg_err %b got %s want edge 16 cfg_err 0 %s",
                         e, cfg_err, fmt(get_res()), fmt(base_res));
      end
   endtask

   task automatic test_busy_reset();
      int e;
      int ndone = 0;
      int first = -1;
      // second start at edge 5 carries a different descriptor and must be dropped
      pulse_start(8, 3, 4, 1, 10);
      repeat (4) @(posedge clk);
      #1;
      tensor_size = 8'd8; kernel_size = 4'd3; channels = 8'd2; stride = 3'd2; kernel_nums = 8'd8;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 6; i <= 30; i++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (first < 0) first = i;
         end
      end
      total++;
      if (ndone != 1 || first != 16) begin
         bad++; $display("FAIL busy_ignore: %0d done pulses first at %0d, want 1 at 16", ndone, first);
      end
      total++;
      if (get_res() !== base_res) begin
         bad++; $display("FAIL busy_data: got %s want %s", fmt(get_res()), fmt(base_res));
      end
      // reset in the middle of a run
      pulse_start(8, 3, 2, 2, 8);
      repeat (8) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      total++;
      if ({busy, done, cfg_err, enable} !== 4'b0000) begin
         bad++; $display("FAIL abort_status: got %b want 0000", {busy, done, cfg_err, enable});
      end
      total++;
      if (get_res() !== zero_res) begin
         bad++; $display("FAIL abort_data: got %s want all zero", fmt(get_res()));
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({busy, done} !== 2'b00) begin
         bad++; $display("FAIL abort_idle: busy/done got %b want 00", {busy, done});
      end
      pulse_start(8, 3, 4, 1, 10);
      wait_done(e);
      total++;
      if (e != 16 || get_res() !== base_res || enable !== 1'b1) begin
         bad++; $display("FAIL abort_rerun: edge %0d enable %b got %s want edge 16 enable 1 %s",
                         e, enable, fmt(get_res()), fmt(base_res));
      end
   endtask

   initial begin
      base_res = mk(6, 8, 36, 4, 3, 2, 1, 5, 4);
      test_reset();
      test_baseline();
      test_exact();
      test_back_to_back();
      test_boundary();
      test_padding();
      test_error();
      test_busy_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
